// File: rtl/gcdlcm_param.sv
// GCD (binary Stein) or LCM (GCD, then restoring divide and shift-add multiply) of two WIDTH-bit operands.
// Latency start->done: GCD <= 2*WIDTH+3, LCM <= 4*WIDTH+4, any zero operand exactly 2 cycles.
// No backpressure: start is taken only in IDLE; starts in other states are dropped.
//
// Ports:
//   clk, rst       rising-edge clock, synchronous active-high reset
//   start, mode    one-cycle request; mode 0 = GCD, 1 = LCM (captured with start)
//   ina, inb       WIDTH-bit operands (captured with start)
//   busy           high from the cycle after accept until done asserts
//   done           one-cycle completion pulse
//   result         2*WIDTH-bit result, held from done until the next accepted start
module gcdlcm_param #(
    parameter int WIDTH = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               mode,
    input  logic [WIDTH-1:0]   ina,
    input  logic [WIDTH-1:0]   inb,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result
);

    // Counts 0..WIDTH-1 for the divide/multiply loops and the Stein shift k.
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {IDLE, GCD, ALIGN, DIV, MUL, FIN} state_t;

    state_t             state;
    logic [WIDTH-1:0]   orig_a;     // untouched copies of the operands
    logic [WIDTH-1:0]   orig_b;
    logic [WIDTH-1:0]   a;          // Stein working registers
    logic [WIDTH-1:0]   b;
    logic [WIDTH-1:0]   g;          // aligned GCD, divisor for the LCM path
    logic [WIDTH-1:0]   q;          // dividend/quotient, then multiplier
    logic [WIDTH-1:0]   rem;        // partial remainder, always < g
    logic [2*WIDTH-1:0] mcand;      // multiplicand shifted left each MUL cycle
    logic [CW-1:0]      k;
    logic [CW-1:0]      cnt;
    logic               mode_r;
    logic               zero_op;

    // Restoring-division step: shift in the next dividend bit, subtract g if it fits.
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH-1:0]   rem_sub;
    logic               rem_ge;

    always_comb begin
        rem_sh  = {rem, q[WIDTH-1]};
        // The true difference is below g, so the low WIDTH bits are exact.
        rem_sub = rem_sh[WIDTH-1:0] - g;
        rem_ge  = (rem_sh >= {1'b0, g});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            orig_a  <= '0;
            orig_b  <= '0;
            a       <= '0;
            b       <= '0;
            g       <= '0;
            q       <= '0;
            rem     <= '0;
            mcand   <= '0;
            k       <= '0;
            cnt     <= '0;
            mode_r  <= 1'b0;
            zero_op <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        orig_a  <= ina;
                        orig_b  <= inb;
                        a       <= ina;
                        b       <= inb;
                        mode_r  <= mode;
                        // Flagged here so a Stein result of A==0 is not confused with a zero operand.
                        zero_op <= (ina == '0) || (inb == '0);
                        k       <= '0;
                        busy    <= 1'b1;
                        state   <= GCD;
                    end
                end

                GCD: begin
                    if (zero_op) begin
                        // One operand is zero, so a|b is the other one (or zero).
                        result <= mode_r ? '0 : {{WIDTH{1'b0}}, a | b};
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= FIN;
                    end else if (a == '0) begin
                        state <= ALIGN;
                    end else begin
                        case ({a[0], b[0]})
                            2'b00: begin
                                a <= a >> 1;
                                b <= b >> 1;
                                k <= k + CW'(1);
                            end
                            2'b01:   a <= a >> 1;
                            2'b10:   b <= b >> 1;
                            default: begin
                                // Both odd: the difference is even, halve it immediately.
                                if (a >= b) a <= (a - b) >> 1;
                                else        b <= (b - a) >> 1;
                            end
                        endcase
                    end
                end

                ALIGN: begin
                    g <= b << k;
                    if (!mode_r) begin
                        result <= {{WIDTH{1'b0}}, b << k};
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= FIN;
                    end else begin
                        q     <= orig_a;
                        rem   <= '0;
                        cnt   <= '0;
                        state <= DIV;
                    end
                end

                DIV: begin
                    q   <= {q[WIDTH-2:0], rem_ge};
                    rem <= rem_ge ? rem_sub : rem_sh[WIDTH-1:0];
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        cnt    <= '0;
                        // result doubles as the product accumulator.
                        result <= '0;
                        mcand  <= {{WIDTH{1'b0}}, orig_b};
                        state  <= MUL;
                    end
                end

                MUL: begin
                    if (q[0]) result <= result + mcand;
                    mcand <= mcand << 1;
                    q     <= q >> 1;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= FIN;
                    end
                end

                FIN: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
